// File: rtl/kernel_scan_ctrl.sv
// Scan sequencer: issues pixel start pulses, holds integration limits for a scan,
// counts pixels/kernels and guards every wait with a watchdog.
module kernel_scan_ctrl #(
    parameter int unsigned PIXELS_PER_KERNEL = 9,
    parameter int unsigned N_KERNELS         = 16,
    parameter int unsigned GAP_CLK           = 2,
    parameter int unsigned WDOG_CLK          = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_start_i,
    input  logic       scan_abort_i,
    input  logic [9:0] loc_max_clk_cfg,
    input  logic [9:0] adj_max_clk_cfg,
    input  logic       pxl_done_i,
    input  logic       kernel_done_i,
    output logic       pxl_start_o,
    output logic [9:0] loc_max_clk,
    output logic [9:0] adj_max_clk,
    output logic [3:0] pxl_idx_o,
    output logic [7:0] kernel_idx_o,
    output logic       busy_o,
    output logic       scan_done_o,
    output logic       err_timeout_o
);

    localparam int unsigned PXL_W = 4;
    localparam int unsigned KRN_W = 8;
    localparam int unsigned CFG_W = 10;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned WD_W  = 12;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_START       = 3'd1;
    localparam logic [2:0] S_WAIT_PXL    = 3'd2;
    localparam logic [2:0] S_GAP         = 3'd3;
    localparam logic [2:0] S_WAIT_KERNEL = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;

    localparam logic [PXL_W-1:0] LAST_PXL = PXL_W'(PIXELS_PER_KERNEL - 1);
    localparam logic [KRN_W-1:0] LAST_KRN = KRN_W'(N_KERNELS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLK - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CLK - 1);
    // With no gap configured, a done event goes straight to the next start.
    localparam logic [2:0]       S_RESUME = (GAP_CLK == 0) ? S_START : S_GAP;

    logic [2:0]       r_state;
    logic [PXL_W-1:0] r_pxl_idx;
    logic [KRN_W-1:0] r_kernel_idx;
    logic [CFG_W-1:0] r_loc;
    logic [CFG_W-1:0] r_adj;
    logic [GAP_W-1:0] r_gap;
    logic [WD_W-1:0]  r_wdog;
    logic             r_err;
    logic             r_pxl_start;
    logic             r_busy;
    logic             r_scan_done;

    logic [2:0]       w_state_nxt;
    logic [PXL_W-1:0] w_pxl_idx_nxt;
    logic [KRN_W-1:0] w_kernel_idx_nxt;
    logic [CFG_W-1:0] w_loc_nxt;
    logic [CFG_W-1:0] w_adj_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic             w_err_nxt;
    logic             w_kernel_cmp;

    // Next-state logic; gap and watchdog counters fall back to zero outside their states.
    always_comb begin
        w_state_nxt      = r_state;
        w_pxl_idx_nxt    = r_pxl_idx;
        w_kernel_idx_nxt = r_kernel_idx;
        w_loc_nxt        = r_loc;
        w_adj_nxt        = r_adj;
        w_err_nxt        = r_err;
        w_gap_nxt        = '0;
        w_wdog_nxt       = '0;
        w_kernel_cmp     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (scan_start_i) begin
                    w_loc_nxt        = loc_max_clk_cfg;
                    w_adj_nxt        = adj_max_clk_cfg;
                    w_pxl_idx_nxt    = '0;
                    w_kernel_idx_nxt = '0;
                    w_err_nxt        = 1'b0;
                    w_state_nxt      = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT_PXL;
            S_WAIT_PXL: begin
                if (pxl_done_i) begin
                    if (r_pxl_idx < LAST_PXL) begin
                        w_pxl_idx_nxt = r_pxl_idx + PXL_W'(1);
                        w_state_nxt   = S_RESUME;
                    end else if (kernel_done_i) begin
                        w_kernel_cmp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_KERNEL;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            S_WAIT_KERNEL: begin
                if (kernel_done_i) begin
                    w_kernel_cmp = 1'b1;
                end else if (r_wdog == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_START;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_kernel_cmp) begin
            w_pxl_idx_nxt = '0;
            if (r_kernel_idx < LAST_KRN) begin
                w_kernel_idx_nxt = r_kernel_idx + KRN_W'(1);
                w_state_nxt      = S_RESUME;
            end else begin
                w_state_nxt = S_DONE;
            end
        end

        // Abort wins over everything and leaves indices and error flag untouched.
        if (scan_abort_i && (r_state != S_IDLE)) begin
            w_state_nxt      = S_IDLE;
            w_pxl_idx_nxt    = r_pxl_idx;
            w_kernel_idx_nxt = r_kernel_idx;
            w_err_nxt        = r_err;
            w_gap_nxt        = '0;
            w_wdog_nxt       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pxl_idx    <= '0;
            r_kernel_idx <= '0;
            r_loc        <= '0;
            r_adj        <= '0;
            r_gap        <= '0;
            r_wdog       <= '0;
            r_err        <= 1'b0;
            r_pxl_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pxl_idx    <= w_pxl_idx_nxt;
            r_kernel_idx <= w_kernel_idx_nxt;
            r_loc        <= w_loc_nxt;
            r_adj        <= w_adj_nxt;
            r_gap        <= w_gap_nxt;
            r_wdog       <= w_wdog_nxt;
            r_err        <= w_err_nxt;
            r_pxl_start  <= (w_state_nxt == S_START);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_scan_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign pxl_start_o   = r_pxl_start;
    assign loc_max_clk   = r_loc;
    assign adj_max_clk   = r_adj;
    assign pxl_idx_o     = r_pxl_idx;
    assign kernel_idx_o  = r_kernel_idx;
    assign busy_o        = r_busy;
    assign scan_done_o   = r_scan_done;
    assign err_timeout_o = r_err;

endmodule

// File: tb/tb_kernel_scan_ctrl.sv
// Directed bench for kernel_scan_ctrl: instance A (gap 2, long watchdog) and
// instance B (gap 0, watchdog 20), both with 9 pixels x 2 kernels.
module tb_kernel_scan_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic       a_start = 0, a_abort = 0, a_pxl_done = 0, a_krn_done = 0;
    logic [9:0] a_loc_cfg = 0, a_adj_cfg = 0;
    logic       a_pxl_start, a_busy, a_sdone, a_err;
    logic [9:0] a_loc, a_adj;
    logic [3:0] a_pidx;
    logic [7:0] a_kidx;

    logic       b_start = 0, b_abort = 0, b_pxl_done = 0, b_krn_done = 0;
    logic [9:0] b_loc_cfg = 0, b_adj_cfg = 0;
    logic       b_pxl_start, b_busy, b_sdone, b_err;
    logic [9:0] b_loc, b_adj;
    logic [3:0] b_pidx;
    logic [7:0] b_kidx;

    always #5 clk = ~clk;

    kernel_scan_ctrl #(.PIXELS_PER_KERNEL(9), .N_KERNELS(2), .GAP_CLK(2), .WDOG_CLK(4095)) u_dut_a (
        .clk(clk), .reset(reset), .scan_start_i(a_start), .scan_abort_i(a_abort),
        .loc_max_clk_cfg(a_loc_cfg), .adj_max_clk_cfg(a_adj_cfg),
        .pxl_done_i(a_pxl_done), .kernel_done_i(a_krn_done),
        .pxl_start_o(a_pxl_start), .loc_max_clk(a_loc), .adj_max_clk(a_adj),
        .pxl_idx_o(a_pidx), .kernel_idx_o(a_kidx), .busy_o(a_busy),
        .scan_done_o(a_sdone), .err_timeout_o(a_err));

    kernel_scan_ctrl #(.PIXELS_PER_KERNEL(9), .N_KERNELS(2), .GAP_CLK(0), .WDOG_CLK(20)) u_dut_b (
        .clk(clk), .reset(reset), .scan_start_i(b_start), .scan_abort_i(b_abort),
        .loc_max_clk_cfg(b_loc_cfg), .adj_max_clk_cfg(b_adj_cfg),
        .pxl_done_i(b_pxl_done), .kernel_done_i(b_krn_done),
        .pxl_start_o(b_pxl_start), .loc_max_clk(b_loc), .adj_max_clk(b_adj),
        .pxl_idx_o(b_pidx), .kernel_idx_o(b_kidx), .busy_o(b_busy),
        .scan_done_o(b_sdone), .err_timeout_o(b_err));

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_pxl_start, a_busy, a_sdone, a_err, a_pidx, a_kidx, a_loc, a_adj} !== 36'd0) begin
            errors++; $display("FAIL reset_a got %h exp 0", {a_pxl_start, a_busy, a_sdone, a_err, a_pidx, a_kidx, a_loc, a_adj});
        end
        checks++;
        if ({b_pxl_start, b_busy, b_sdone, b_err, b_pidx, b_kidx, b_loc, b_adj} !== 36'd0) begin
            errors++; $display("FAIL reset_b got %h exp 0", {b_pxl_start, b_busy, b_sdone, b_err, b_pidx, b_kidx, b_loc, b_adj});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_busy, b_busy} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset got %b exp 00", {a_busy, b_busy});
        end
    endtask

    // Full 2-kernel scan with a pixel model answering each start 5 cycles later.
    task automatic test_full_scan();
        int pulses = 0, last_t = 0, pend = -1, kpend = -1, pix_done = 0;
        int sdone = 0, bad_idx = 0, bad_cfg = 0;
        bit fin = 0;
        @(negedge clk);
        a_loc_cfg = 10'd400; a_adj_cfg = 10'd200; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            a_pxl_done = 1'b0; a_krn_done = 1'b0;
            if (t == 12) begin a_loc_cfg = 10'd7; a_adj_cfg = 10'd9; end
            if (a_loc !== 10'd400 || a_adj !== 10'd200) bad_cfg++;
            if (kpend > 0) kpend--;
            if (kpend == 0) begin a_krn_done = 1'b1; kpend = -1; end
            if (pend > 0) pend--;
            if (pend == 0) begin
                a_pxl_done = 1'b1; pend = -1; pix_done++;
                if (pix_done % 9 == 0) kpend = 3;
            end
            if (a_pxl_start === 1'b1) begin
                if (pulses % 9 != 0) begin
                    checks++;
                    if (t - last_t != 8) begin
                        errors++; $display("FAIL pulse_spacing got %0d exp 8", t - last_t);
                    end
                end
                if (a_pidx !== 4'(pulses % 9) || a_kidx !== 8'(pulses / 9)) bad_idx++;
                last_t = t; pulses++; pend = 5;
            end
            if (a_sdone === 1'b1) begin
                sdone++;
                checks++;
                if (a_busy !== 1'b1) begin
                    errors++; $display("FAIL busy_during_done got %b exp 1", a_busy);
                end
            end
            if (sdone > 0 && a_busy === 1'b0) fin = 1;
        end
        a_pxl_done = 1'b0; a_krn_done = 1'b0;
        checks++; if (!fin)         begin errors++; $display("FAIL scan_finish got 0 exp 1"); end
        checks++; if (pulses != 18) begin errors++; $display("FAIL pulse_count got %0d exp 18", pulses); end
        checks++; if (sdone != 1)   begin errors++; $display("FAIL scan_done_count got %0d exp 1", sdone); end
        checks++; if (a_kidx !== 8'd1) begin errors++; $display("FAIL final_kidx got %0d exp 1", a_kidx); end
        checks++; if (a_pidx !== 4'd0) begin errors++; $display("FAIL final_pidx got %0d exp 0", a_pidx); end
        checks++; if (bad_idx != 0) begin errors++; $display("FAIL idx_at_start got %0d bad exp 0", bad_idx); end
        checks++; if (bad_cfg != 0) begin errors++; $display("FAIL cfg_hold got %0d bad exp 0", bad_cfg); end
    endtask

    // Stray inputs in WAIT_KERNEL, then abort during kernel 1 pixel 4.
    task automatic test_abort_stray();
        int pend = -1, kpend = -1, pix_done = 0, sdone = 0, abort_cd = -1;
        int aborted = 0, bad_post = 0;
        bit stray_chk = 0, fin = 0;
        @(negedge clk);
        a_loc_cfg = 10'd400; a_adj_cfg = 10'd200; a_start = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 400 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            a_start = 1'b0; a_abort = 1'b0; a_pxl_done = 1'b0; a_krn_done = 1'b0;
            if (a_sdone === 1'b1) sdone++;
            if (aborted > 0) begin
                if (aborted == 1) begin
                    checks++;
                    if ({a_busy, a_pxl_start, a_err, a_pidx, a_kidx} !== {1'b0, 1'b0, 1'b0, 4'd4, 8'd1}) begin
                        errors++; $display("FAIL abort_state got busy=%b start=%b err=%b p=%0d k=%0d exp 0 0 0 4 1",
                                           a_busy, a_pxl_start, a_err, a_pidx, a_kidx);
                    end
                end
                if (a_busy !== 1'b0 || a_pxl_start !== 1'b0) bad_post++;
                aborted++;
                if (aborted > 10) fin = 1;
            end
            if (stray_chk) begin
                stray_chk = 0;
                checks++;
                if ({a_busy, a_pidx, a_kidx} !== {1'b1, 4'd8, 8'd0}) begin
                    errors++; $display("FAIL stray_ignored got busy=%b p=%0d k=%0d exp 1 8 0", a_busy, a_pidx, a_kidx);
                end
            end
            if (kpend > 0) kpend--;
            if (kpend == 2) begin a_pxl_done = 1'b1; a_start = 1'b1; stray_chk = 1; end
            if (kpend == 0) begin a_krn_done = 1'b1; kpend = -1; end
            if (pend > 0) pend--;
            if (pend == 0) begin
                a_pxl_done = 1'b1; pend = -1; pix_done++;
                if (pix_done % 9 == 0) kpend = 3;
            end
            if (abort_cd > 0) abort_cd--;
            if (abort_cd == 0) begin a_abort = 1'b1; abort_cd = -1; aborted = 1; end
            if (a_pxl_start === 1'b1 && aborted == 0) begin
                if (a_kidx === 8'd1 && a_pidx === 4'd4) abort_cd = 2;
                pend = 5;
            end
        end
        a_start = 1'b0; a_abort = 1'b0; a_pxl_done = 1'b0; a_krn_done = 1'b0;
        checks++; if (!fin)         begin errors++; $display("FAIL abort_reached got 0 exp 1"); end
        checks++; if (sdone != 0)   begin errors++; $display("FAIL abort_no_done got %0d exp 0", sdone); end
        checks++; if (bad_post != 0) begin errors++; $display("FAIL abort_stays_idle got %0d bad exp 0", bad_post); end
    endtask

    // Watchdog 20: WAIT_PXL entered at edge 1, so busy drops after edge 21.
    task automatic test_timeout();
        int first_idle = -1, sd = 0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int n = 0; n < 100 && first_idle < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (b_sdone === 1'b1) sd++;
            if (n == 20) begin
                checks++;
                if (b_err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", b_err); end
            end
            if (b_busy === 1'b0) first_idle = n;
        end
        checks++; if (first_idle != 21) begin errors++; $display("FAIL timeout_cycle got %0d exp 21", first_idle); end
        checks++; if (b_err !== 1'b1)   begin errors++; $display("FAIL err_set got %b exp 1", b_err); end
        checks++; if (sd != 0)          begin errors++; $display("FAIL timeout_no_done got %0d exp 0", sd); end
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        checks++;
        if ({b_err, b_busy} !== 2'b01) begin errors++; $display("FAIL err_clear got err=%b busy=%b exp 0 1", b_err, b_busy); end
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        checks++;
        if (b_busy !== 1'b0) begin errors++; $display("FAIL abort_b got %b exp 0", b_busy); end
        checks++;
        if (b_err !== 1'b0) begin errors++; $display("FAIL abort_keeps_err got %b exp 0", b_err); end
    endtask

    // Gap 0 with kernel_done coincident with the 9th pixel done.
    task automatic test_gap0_coincident();
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (b_pxl_start !== 1'b1 || b_pidx !== 4'(i)) begin
                errors++; $display("FAIL gap0_start got start=%b p=%0d exp 1 %0d", b_pxl_start, b_pidx, i);
            end
            repeat (5) @(negedge clk);
            b_pxl_done = 1'b1;
            if (i == 8) b_krn_done = 1'b1;
            @(negedge clk);
            b_pxl_done = 1'b0; b_krn_done = 1'b0;
        end
        checks++;
        if ({b_pxl_start, b_pidx, b_kidx} !== {1'b1, 4'd0, 8'd1}) begin
            errors++; $display("FAIL coincident_kernel got start=%b p=%0d k=%0d exp 1 0 1", b_pxl_start, b_pidx, b_kidx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({b_busy, b_kidx} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL kidx_once got busy=%b k=%0d exp 1 1", b_busy, b_kidx);
        end
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
    endtask

    // Reset while waiting for kernel_done, then a fresh scan.
    task automatic test_reset_wait_kernel();
        int w;
        @(negedge clk);
        a_loc_cfg = 10'd400; a_adj_cfg = 10'd200; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (a_pxl_start !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            checks++;
            if (w >= 20) begin errors++; $display("FAIL wk_start_wait got %0d exp <20", w); end
            repeat (2) @(negedge clk);
            a_pxl_done = 1'b1;
            @(negedge clk);
            a_pxl_done = 1'b0;
        end
        checks++;
        if ({a_busy, a_pidx} !== {1'b1, 4'd8}) begin
            errors++; $display("FAIL wk_reached got busy=%b p=%0d exp 1 8", a_busy, a_pidx);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_pxl_start, a_busy, a_sdone, a_err, a_pidx, a_kidx, a_loc, a_adj} !== 36'd0) begin
            errors++; $display("FAIL async_reset got %h exp 0", {a_pxl_start, a_busy, a_sdone, a_err, a_pidx, a_kidx, a_loc, a_adj});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_pxl_start} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle got %b exp 00", {a_busy, a_pxl_start});
        end
        a_loc_cfg = 10'd123; a_adj_cfg = 10'd45; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if ({a_busy, a_pxl_start, a_pidx, a_kidx, a_loc, a_adj} !== {1'b1, 1'b1, 4'd0, 8'd0, 10'd123, 10'd45}) begin
            errors++; $display("FAIL fresh_scan got busy=%b start=%b p=%0d k=%0d loc=%0d adj=%0d exp 1 1 0 0 123 45",
                               a_busy, a_pxl_start, a_pidx, a_kidx, a_loc, a_adj);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_full_scan();
        test_abort_stray();
        test_timeout();
        test_gap0_coincident();
        test_reset_wait_kernel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
